cic_decim_mc: RTL and testbench

- Multi-channel, parametrised N-stage CIC decimator for the PDM microphone array.
- One shared clock. PDM bits are qualified by a sample strobe, so no divided clock is needed.
- Per-channel integrators run at the PDM rate.
- A single comb datapath is time-multiplexed across channels after each decimation event.
- The block emits a serialised stream of signed PCM samples, tagged by channel, to the beamforming front end.

---
 rtl/cic_pkg.sv | 47 ++++
 rtl/cic_int_bank.sv | 44 ++++
 rtl/cic_decim_mc.sv | 163 ++++++++++++++++
 tb/tb_cic_decim_mc.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// cic_pkg: shared types and helpers for the multi-channel CIC decimator.
//   acc_w_f    - accumulator width N*R_LOG2+2 (holds the full R^N gain plus sign)
//   shift_f    - right shift that brings the comb result down to OUT_W
//   pdm_map    - PDM bit to +1/-1
//   sat_narrow - clamp a wide signed value into an out_w-bit signed range
//   sat_hit    - flags when sat_narrow would clip
//   seq_state_t - comb sequencer states
package cic_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  function automatic int acc_w_f(input int n, input int r_log2);
    return n * r_log2 + 2;
  endfunction

  function automatic int shift_f(input int n, input int r_log2, input int out_w);
    return n * r_log2 + 1 - out_w;
  endfunction

  // Bit 1 -> +1, bit 0 -> -1; callers truncate to their accumulator width.
  function automatic logic signed [63:0] pdm_map(input logic b);
    return b ? 64'sd1 : -64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] x,
                                                    input int out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic logic sat_hit(input logic signed [63:0] x, input int out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    return (x > hi) || (x < lo);
  endfunction

endpackage

// File: rtl/cic_int_bank.sv
// cic_int_bank: CH x N array of wrapping integrators running at the PDM rate.
//   clk, rst  - system clock, synchronous active-high reset
//   pdm_en    - sample strobe; integrators only move when high
//   pdm_in    - one PDM bit per channel
//   int_last  - registered last-stage integrator value of each channel
module cic_int_bank
  import cic_pkg::*;
#(
  parameter int CH    = 4,
  parameter int N     = 3,
  parameter int ACC_W = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pdm_en,
  input  logic [CH-1:0]             pdm_in,
  output logic [CH-1:0][ACC_W-1:0]  int_last
);

  logic [ACC_W-1:0] integ [CH][N];

  // NOTE: the integrator array is a register bank, not a RAM, so it is cleared
  // explicitly on reset; a stale sum would corrupt every later output.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CH; c++)
        for (int j = 0; j < N; j++)
          integ[c][j] <= '0;
    end else if (pdm_en) begin
      // NOTE: non-blocking assignments make stage j add stage j-1's value from
      // before this edge, which is exactly the registered cascade we want.
      for (int c = 0; c < CH; c++) begin
        integ[c][0] <= integ[c][0] + ACC_W'(pdm_map(pdm_in[c]));
        for (int j = 1; j < N; j++)
          integ[c][j] <= integ[c][j] + integ[c][j-1];
      end
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_last
    assign int_last[c] = integ[c][N-1];
  end

endmodule

// File: rtl/cic_decim_mc.sv
// cic_decim_mc: multi-channel N-stage CIC decimator (R = 2^R_LOG2) with a
// single time-multiplexed comb datapath.
//   clk, rst    - system clock, synchronous active-high reset
//   pdm_en      - sample strobe qualifying pdm_in
//   pdm_in      - one PDM bit per channel
//   gain_shift  - (only with CIC_GAIN_EN) left shift applied before scaling,
//                 sampled at capture and held for the burst
//   out_valid   - one-cycle qualifier per output sample
//   out_chan    - channel index of out_data
//   out_data    - signed PCM sample
//   out_sat     - sample was clipped
// Optional feature macro: CIC_GAIN_EN.
module cic_decim_mc
  import cic_pkg::*;
#(
  parameter int  CH     = 4,
  parameter int  N      = 3,
  parameter int  R_LOG2 = 6,
  parameter int  OUT_W  = 16,
  localparam int CHAN_W = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pdm_en,
  input  logic [CH-1:0]            pdm_in,
`ifdef CIC_GAIN_EN
  input  logic [2:0]               gain_shift,
`endif
  output logic                     out_valid,
  output logic [CHAN_W-1:0]        out_chan,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_sat
);

  localparam int ACC_W = acc_w_f(N, R_LOG2);
  localparam int SHIFT = shift_f(N, R_LOG2, OUT_W);
  localparam int WIDE  = ACC_W + 7;

  logic [CH-1:0][ACC_W-1:0] int_last;
  logic [R_LOG2-1:0]        dec_cnt;
  logic                     cap_pend;   // edge E just accepted the R-th sample
  logic [ACC_W-1:0]         cap_bank [CH];
  logic [ACC_W-1:0]         comb_dly [CH][N];
  seq_state_t               state_q, state_d;
  logic [CHAN_W-1:0]        k_q, k_d;
  logic [2:0]               gain_q;

  logic [ACC_W-1:0]         c_tap [N+1];
  logic signed [WIDE-1:0]   wide_val;
  logic signed [WIDE-1:0]   scaled;
  logic signed [63:0]       scaled64;
  logic [OUT_W-1:0]         data_d;
  logic                     sat_d;

  cic_int_bank #(
    .CH    (CH),
    .N     (N),
    .ACC_W (ACC_W)
  ) u_int_bank (
    .clk      (clk),
    .rst      (rst),
    .pdm_en   (pdm_en),
    .pdm_in   (pdm_in),
    .int_last (int_last)
  );

`ifdef CIC_GAIN_EN
  always_ff @(posedge clk) begin
    if (rst)           gain_q <= '0;
    else if (cap_pend) gain_q <= gain_shift;
  end
`else
  assign gain_q = 3'd0;
`endif

  // Comb chain for the channel currently selected by the sequencer (M = 1).
  always_comb begin
    c_tap[0] = cap_bank[k_q];
    for (int j = 0; j < N; j++)
      c_tap[j+1] = c_tap[j] - comb_dly[k_q][j];
  end

  // Gain, scale and clamp. The widened value keeps every bit the left shift
  // produces so the clamp sees the true magnitude.
  always_comb begin
    wide_val = WIDE'(signed'(c_tap[N])) <<< gain_q;
    scaled   = wide_val >>> SHIFT;
    scaled64 = 64'(scaled);
    data_d   = OUT_W'(sat_narrow(scaled64, OUT_W));
    sat_d    = sat_hit(scaled64, OUT_W);
  end

  // NOTE: next-state signals take their hold value first, so no path through
  // the case leaves them unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: begin
        if (cap_pend) begin
          state_d = RUN;
          k_d     = '0;
        end
      end
      RUN: begin
        if (k_q == CHAN_W'(CH - 1)) begin
          state_d = IDLE;
          k_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_cnt   <= '0;
      cap_pend  <= 1'b0;
      out_valid <= 1'b0;
      out_chan  <= '0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      for (int c = 0; c < CH; c++) begin
        cap_bank[c] <= '0;
        for (int j = 0; j < N; j++)
          comb_dly[c][j] <= '0;
      end
    end else begin
      if (pdm_en) dec_cnt <= dec_cnt + 1'b1;
      cap_pend <= pdm_en && (dec_cnt == '1);

      // The capture bank decouples the still-running integrators from the
      // comb burst that follows.
      if (cap_pend) begin
        for (int c = 0; c < CH; c++)
          cap_bank[c] <= int_last[c];
      end

      out_valid <= 1'b0;
      if (state_q == RUN) begin
        for (int j = 0; j < N; j++)
          comb_dly[k_q][j] <= c_tap[j];
        out_valid <= 1'b1;
        out_chan  <= k_q;
        out_data  <= data_d;
        out_sat   <= sat_d;
      end
    end
  end

endmodule

// File: tb/tb_cic_decim_mc.sv
// tb_cic_decim_mc: directed self-checking bench for cic_decim_mc
// (CH=4, N=3, R_LOG2=6, OUT_W=16).
// Channel patterns: ch0 all 1s, ch1 all 0s, ch2 1010..., ch3 1000 repeating,
// indexed by the count of accepted samples since reset.
module tb_cic_decim_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        pdm_en;
  logic [3:0]  pdm_in;
  logic        out_valid;
  logic [1:0]  out_chan;
  logic [15:0] out_data;
  logic        out_sat;
`ifdef CIC_GAIN_EN
  logic [2:0]  gain_shift = 3'd0;
`endif

  cic_decim_mc #(
    .CH     (4),
    .N      (3),
    .R_LOG2 (6),
    .OUT_W  (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pdm_en     (pdm_en),
    .pdm_in     (pdm_in),
`ifdef CIC_GAIN_EN
    .gain_shift (gain_shift),
`endif
    .out_valid  (out_valid),
    .out_chan   (out_chan),
    .out_data   (out_data),
    .out_sat    (out_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] ch;
    logic [15:0] d;
    logic       s;
  } obs_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc = 0;
  int   en_period = 1;   // 0 = strobe held low
  int   en_phase = 0;
  obs_t obs_q[$];
  int   e_q[$];          // cycle of each edge E (every 64th accepted sample)

  // Hand-derived expectations.
  // First burst after reset: last-stage integrator after 64 samples, d=0,
  // >>>3. ch0: C(64,3)=41664 -> 5208; ch1: -5208; ch2: 992 -> 124;
  // ch3: -19328 -> -2416.
  logic [15:0] first_d [4] = '{16'h1458, 16'hEBA8, 16'h007C, 16'hF690};
  // Steady state: gain 2^18 times channel mean (+1, -1, 0, -0.5), >>>3, clamp.
  logic [15:0] steady_d [4] = '{16'h7FFF, 16'h8000, 16'h0000, 16'hC000};
  logic        steady_s [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic pat_bit(input int ch, input int s);
    case (ch)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return (s % 2) == 0;
      default: return (s % 4) == 0;
    endcase
  endfunction

  task automatic tick();
    logic take;
    pdm_en = (en_period != 0) && (en_phase == 0);
    if (en_period != 0) en_phase = (en_phase + 1) % en_period;
    for (int c = 0; c < 4; c++) pdm_in[c] = pat_bit(c, acc);
    take = pdm_en && !rst;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      acc = 0;
    end else if (take) begin
      acc++;
      if (acc % 64 == 0) e_q.push_back(cyc);
    end
    if (out_valid) obs_q.push_back('{cyc, out_chan, out_data, out_sat});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_logs();
    obs_q.delete();
    e_q.delete();
  endtask

  task automatic check_bursts(input string tag, input int nb, input int spacing);
    int n;
    check($sformatf("%s_count", tag), obs_q.size(), nb * 4);
    n = (obs_q.size() < nb * 4) ? obs_q.size() : nb * 4;
    for (int i = 0; i < n; i++) begin
      int b;
      int k;
      b = i / 4;
      k = i % 4;
      check($sformatf("%s_b%0d_chan%0d", tag, b, k), obs_q[i].ch, k);
      if (b < e_q.size())
        check($sformatf("%s_b%0d_k%0d_cycle", tag, b, k), obs_q[i].cyc, e_q[b] + 2 + k);
      if (k == 0 && b > 0)
        check($sformatf("%s_b%0d_spacing", tag, b), obs_q[i].cyc - obs_q[i-4].cyc, spacing);
      if (b == 0) begin
        check($sformatf("%s_b0_data%0d", tag, k), obs_q[i].d, first_d[k]);
        check($sformatf("%s_b0_sat%0d", tag, k), obs_q[i].s, 1'b0);
      end
      if (b >= 3) begin
        check($sformatf("%s_b%0d_data%0d", tag, b, k), obs_q[i].d, steady_d[k]);
        check($sformatf("%s_b%0d_sat%0d", tag, b, k), obs_q[i].s, steady_s[k]);
      end
    end
  endtask

  initial begin
    int n;
    rst    = 1'b1;
    pdm_en = 1'b0;
    pdm_in = '0;

    // Reset state with the strobe toggling.
    run(3);
    check("rst_valid", out_valid, 1'b0);
    check("rst_chan", out_chan, 2'd0);
    check("rst_data", out_data, 16'h0000);
    check("rst_sat", out_sat, 1'b0);
    rst = 1'b0;
    clear_logs();

    // Strobe held low: nothing integrates, nothing comes out.
    en_period = 0;
    run(200);
    check("idle_outputs", obs_q.size(), 0);
    check("idle_acc", acc, 0);

    // Strobe every cycle: 8 bursts.
    clear_logs();
    en_period = 1;
    en_phase  = 0;
    run(64 * 8 + 10);
    check_bursts("A", 8, 64);

    // Strobe every 3rd cycle after a fresh reset: bursts 192 clocks apart.
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    clear_logs();
    en_period = 3;
    en_phase  = 0;
    run(192 * 7 + 10);
    check_bursts("B", 7, 192);

    // Reset during k=1 of the first burst.
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    clear_logs();
    en_period = 1;
    en_phase  = 0;
    n = 0;
    while (obs_q.size() == 0 && n < 200) begin
      tick();
      n++;
    end
    check("C_first_out_seen", obs_q.size(), 1);
    rst = 1'b1;
    tick();
    check("C_abort_valid", out_valid, 1'b0);
    check("C_abort_data", out_data, 16'h0000);
    rst = 1'b0;
    clear_logs();
    run(64 * 2 + 10);
    check_bursts("C", 2, 64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
